instruction_sequencer: RTL and testbench

Fetch-and-issue front end placed directly upstream of `core`. It walks a program counter through a synchronous-read instruction memory and presents each instruction on `core`'s instruction input with a one-cycle `start` pulse. It waits for `core`'s `busy` to rise and fall before issuing the next instruction. It prefetches the next instruction while the core executes, and it stops on a halt encoding or when the handshake times out.

---
 rtl/instruction_sequencer_if.sv | 22 ++
 rtl/instruction_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_instruction_sequencer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// Instruction memory read port plus the start/busy handshake towards the core.
interface instruction_sequencer_if #(
  parameter int INSTR_WIDTH = 32,
  parameter int ADDR_WIDTH  = 8
);
  logic [ADDR_WIDTH-1:0]  memAddr;
  logic                   memReadEnable;
  logic [INSTR_WIDTH-1:0] memData;
  logic [INSTR_WIDTH-1:0] instructionOut;
  logic                   coreStart;
  logic                   coreBusy;

  modport master (
    output memAddr, memReadEnable, instructionOut, coreStart,
    input  memData, coreBusy
  );

  modport slave (
    input  memAddr, memReadEnable, instructionOut, coreStart,
    output memData, coreBusy
  );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetch-and-issue front end: walks pc through a synchronous-read instruction
// memory, issues each word to the core with a start pulse and prefetches the next.
module instruction_sequencer #(
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ADDR_WIDTH  = 8,
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = {INSTR_WIDTH{1'b0}},
  parameter int                     ACK_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [ADDR_WIDTH-1:0] startAddr,
  instruction_sequencer_if.master bus,
  output logic                  running,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [15:0]           retired
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    ISSUE    = 3'd3,
    EXEC     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t                 state_r;
  logic [ADDR_WIDTH-1:0]  pc_r;
  logic [ADDR_WIDTH-1:0]  mem_addr_r;
  logic                   mem_re_r;
  logic [INSTR_WIDTH-1:0] instr_r;
  logic [INSTR_WIDTH-1:0] pref_r;
  logic                   pref_pending_r;
  logic                   busy_seen_r;
  logic [CW-1:0]          tmo_cnt_r;
  logic                   core_start_r;
  logic                   running_r;
  logic                   done_r;
  logic                   error_r;
  logic [15:0]            retired_r;

  logic [ADDR_WIDTH-1:0]  pc_adv_s;
  logic [INSTR_WIDTH-1:0] pref_s;

  // Prefetch bypass: the word landing this cycle is usable by the completion decision.
  always_comb begin
    pc_adv_s = pc_r;
    pref_s   = pref_r;
    if (pref_pending_r) begin
      pc_adv_s = pc_r + ADDR_WIDTH'(1);
      pref_s   = bus.memData;
    end else begin
      pc_adv_s = pc_r;
      pref_s   = pref_r;
    end
  end

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r        <= IDLE;
      pc_r           <= {ADDR_WIDTH{1'b0}};
      mem_addr_r     <= {ADDR_WIDTH{1'b0}};
      mem_re_r       <= 1'b0;
      instr_r        <= {INSTR_WIDTH{1'b0}};
      pref_r         <= {INSTR_WIDTH{1'b0}};
      pref_pending_r <= 1'b0;
      busy_seen_r    <= 1'b0;
      tmo_cnt_r      <= {CW{1'b0}};
      core_start_r   <= 1'b0;
      running_r      <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      retired_r      <= 16'd0;
    end else begin
      core_start_r <= 1'b0;
      mem_re_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (run) begin
            state_r    <= FETCH;
            pc_r       <= startAddr;
            retired_r  <= 16'd0;
            error_r    <= 1'b0;
            mem_re_r   <= 1'b1;
            mem_addr_r <= startAddr;
            running_r  <= 1'b1;
            done_r     <= 1'b0;
          end else begin
            running_r <= 1'b0;
            done_r    <= 1'b0;
          end
        end
        FETCH: begin
          state_r <= WAIT_MEM;
        end
        WAIT_MEM: begin
          instr_r <= bus.memData;
          pc_r    <= pc_r + ADDR_WIDTH'(1);
          if (bus.memData == HALT_INSTR) begin
            state_r   <= DONE;
            running_r <= 1'b0;
            done_r    <= 1'b1;
          end else begin
            state_r      <= ISSUE;
            core_start_r <= 1'b1;
            mem_re_r     <= 1'b1;
            mem_addr_r   <= pc_r + ADDR_WIDTH'(1);
          end
        end
        ISSUE: begin
          busy_seen_r    <= 1'b0;
          tmo_cnt_r      <= {CW{1'b0}};
          pref_pending_r <= 1'b1;
          state_r        <= EXEC;
        end
        EXEC: begin
          if (pref_pending_r) begin
            pref_r         <= bus.memData;
            pref_pending_r <= 1'b0;
            pc_r           <= pc_adv_s;
          end
          if (bus.coreBusy) begin
            busy_seen_r <= 1'b1;
          end
          // error is raised one cycle ahead of the move to DONE
          if (tmo_cnt_r == TIMEOUT_C) begin
            state_r   <= DONE;
            running_r <= 1'b0;
            done_r    <= 1'b1;
          end else if (!busy_seen_r && !bus.coreBusy) begin
            tmo_cnt_r <= tmo_cnt_r + CW'(1);
            if ((tmo_cnt_r + CW'(1)) == TIMEOUT_C) begin
              error_r <= 1'b1;
            end
          end else if (busy_seen_r && !bus.coreBusy) begin
            if (retired_r != 16'hFFFF) begin
              retired_r <= retired_r + 16'd1;
            end
            if (pref_s == HALT_INSTR) begin
              state_r   <= DONE;
              running_r <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              instr_r      <= pref_s;
              state_r      <= ISSUE;
              core_start_r <= 1'b1;
              mem_re_r     <= 1'b1;
              mem_addr_r   <= pc_adv_s;
            end
          end
        end
        DONE: begin
          if (!run) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          running_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memAddr        = mem_addr_r;
  assign bus.memReadEnable  = mem_re_r;
  assign bus.instructionOut = instr_r;
  assign bus.coreStart      = core_start_r;
  assign running            = running_r;
  assign done               = done_r;
  assign error              = error_r;
  assign pc                 = pc_r;
  assign retired            = retired_r;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench for instruction_sequencer with a synchronous memory and a
// fixed-length busy core model.
module tb_instruction_sequencer;
  localparam int IW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          run;
  logic [AW-1:0] startAddr;
  logic          running;
  logic          done;
  logic          error;
  logic [AW-1:0] pc;
  logic [15:0]   retired;

  instruction_sequencer_if #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  instruction_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .startAddr (startAddr),
    .bus       (bus),
    .running   (running),
    .done      (done),
    .error     (error),
    .pc        (pc),
    .retired   (retired)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] mem [0:255];
  int            busy_len = 4;
  int            busy_cnt;
  int            cyc = 0;
  int            base = 0;
  int            starts[$];
  logic [IW-1:0] words[$];
  logic [IW-1:0] cur_word = 32'h0;
  int            instr_err = 0;
  int            overlap_err = 0;
  int            vectors = 0;
  int            miscompares = 0;

  // memory with one-cycle read latency, plus free-running cycle count
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.memReadEnable) bus.memData <= mem[bus.memAddr];
  end

  // core model: busy for busy_len cycles starting the cycle after start
  always @(posedge clk or negedge reset) begin
    if (!reset) busy_cnt <= 0;
    else if (bus.coreStart && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.coreBusy = (busy_cnt != 0);

  // start-pulse log and instruction stability monitor
  always @(negedge clk) begin
    if (bus.coreStart) begin
      starts.push_back(cyc - base + 1);
      words.push_back(bus.instructionOut);
      cur_word = bus.instructionOut;
      if (bus.coreBusy) overlap_err++;
    end
    if (bus.coreBusy && bus.instructionOut !== cur_word) instr_err++;
  end

  task automatic go(input logic [AW-1:0] a, input bit hold);
    @(negedge clk);
    startAddr = a;
    run = 1'b1;
    @(posedge clk);
    #1;
    base = cyc;
    starts.delete();
    words.delete();
    instr_err = 0;
    overlap_err = 0;
    if (!hold) run = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc - base + 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; run = 1'b0; startAddr = 8'h00;
    #2;
    vectors++;
    if ({bus.memAddr, bus.memReadEnable, bus.instructionOut, bus.coreStart,
         running, done, error, pc, retired} !== {(AW+1+IW+1+3+AW+16){1'b0}}) begin
      $display("FAIL reset_state: got addr=%h re=%b instr=%h start=%b run=%b done=%b err=%b pc=%h ret=%h, expected all 0",
               bus.memAddr, bus.memReadEnable, bus.instructionOut, bus.coreStart, running, done, error, pc, retired);
      miscompares++;
    end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (running !== 1'b0 || done !== 1'b0) begin
      $display("FAIL idle_after_reset: running=%b done=%b, expected 0 0", running, done);
      miscompares++;
    end
  endtask

  task automatic test_program;
    int at;
    busy_len = 4;
    go(8'h10, 1'b0);
    @(negedge clk);
    vectors++;
    if (running !== 1'b1 || bus.memReadEnable !== 1'b1 || bus.memAddr !== 8'h10) begin
      $display("FAIL fetch_cycle1: running=%b re=%b addr=%h, expected 1 1 10", running, bus.memReadEnable, bus.memAddr);
      miscompares++;
    end
    wait_done(60, at);
    vectors++;
    if (at !== 15) begin $display("FAIL prog_done_cycle: got %0d expected 15", at); miscompares++; end
    vectors++;
    if (starts.size() !== 2) begin $display("FAIL prog_pulses: got %0d expected 2", starts.size()); miscompares++; end
    else begin
      vectors++;
      if (starts[0] !== 3 || starts[1] !== 9) begin
        $display("FAIL prog_pulse_cycles: got %0d,%0d expected 3,9", starts[0], starts[1]); miscompares++;
      end
      vectors++;
      if (words[0] !== 32'h00500093 || words[1] !== 32'h00300113) begin
        $display("FAIL prog_words: got %h,%h expected 00500093,00300113", words[0], words[1]); miscompares++;
      end
    end
    vectors++;
    if (instr_err !== 0 || overlap_err !== 0) begin
      $display("FAIL prog_stability: instr_err=%0d overlap=%0d expected 0 0", instr_err, overlap_err); miscompares++;
    end
    vectors++;
    if (retired !== 16'd2 || pc !== 8'h13 || error !== 1'b0) begin
      $display("FAIL prog_final: retired=%0d pc=%h err=%b expected 2 13 0", retired, pc, error); miscompares++;
    end
  endtask

  task automatic test_halt_first;
    int at;
    go(8'h00, 1'b0);
    wait_done(20, at);
    vectors++;
    if (at !== 3) begin $display("FAIL halt_done_cycle: got %0d expected 3", at); miscompares++; end
    vectors++;
    if (starts.size() !== 0 || retired !== 16'd0 || error !== 1'b0 || pc !== 8'h01) begin
      $display("FAIL halt_final: pulses=%0d retired=%0d err=%b pc=%h expected 0 0 0 01",
               starts.size(), retired, error, pc);
      miscompares++;
    end
  endtask

  task automatic test_timeout;
    int at;
    int err_at;
    busy_len = 0;
    go(8'h20, 1'b0);
    err_at = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (error) begin err_at = cyc - base + 1; break; end
    end
    vectors++;
    if (err_at !== 8 || done !== 1'b0) begin
      $display("FAIL timeout_error_cycle: got %0d done=%b expected 8 0", err_at, done); miscompares++;
    end
    wait_done(10, at);
    vectors++;
    if (at !== 9 || retired !== 16'd0 || starts.size() !== 1) begin
      $display("FAIL timeout_done: cycle=%0d retired=%0d pulses=%0d expected 9 0 1", at, retired, starts.size());
      miscompares++;
    end
    busy_len = 4;
    go(8'h00, 1'b0);
    @(negedge clk);
    vectors++;
    if (error !== 1'b0) begin $display("FAIL timeout_cleared: error=%b expected 0", error); miscompares++; end
    wait_done(20, at);
  endtask

  task automatic test_wrap;
    int at;
    busy_len = 3;
    go(8'hFF, 1'b0);
    wait_done(40, at);
    vectors++;
    if (at !== 8) begin $display("FAIL wrap_done_cycle: got %0d expected 8", at); miscompares++; end
    vectors++;
    if (starts.size() !== 1 || pc !== 8'h01 || retired !== 16'd1) begin
      $display("FAIL wrap_final: pulses=%0d pc=%h retired=%0d expected 1 01 1", starts.size(), pc, retired);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid;
    int at;
    busy_len = 4;
    go(8'h30, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (starts.size() >= 2) break;
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({bus.coreStart, bus.memReadEnable, bus.memAddr, bus.instructionOut, running, done, error, pc, retired}
        !== {(1+1+AW+IW+3+AW+16){1'b0}}) begin
      $display("FAIL midreset_outputs: start=%b re=%b run=%b pc=%h retired=%0d expected all 0",
               bus.coreStart, bus.memReadEnable, running, pc, retired);
      miscompares++;
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (starts.size() !== 2) begin $display("FAIL midreset_pulses: got %0d expected 2", starts.size()); miscompares++; end
    reset = 1'b1;
    go(8'h30, 1'b0);
    wait_done(80, at);
    vectors++;
    if (at !== 21 || retired !== 16'd3 || starts.size() !== 3) begin
      $display("FAIL rerun_after_reset: done=%0d retired=%0d pulses=%0d expected 21 3 3", at, retired, starts.size());
      miscompares++;
    end else begin
      vectors++;
      if (starts[0] !== 3 || words[0] !== 32'h0000000A) begin
        $display("FAIL rerun_first_issue: cycle=%0d word=%h expected 3 0000000a", starts[0], words[0]);
        miscompares++;
      end
    end
  endtask

  task automatic test_run_held;
    int at;
    busy_len = 4;
    go(8'h00, 1'b1);
    wait_done(20, at);
    repeat (5) @(negedge clk);
    vectors++;
    if (done !== 1'b1 || running !== 1'b0 || starts.size() !== 0) begin
      $display("FAIL held_run_stays_done: done=%b running=%b pulses=%0d expected 1 0 0", done, running, starts.size());
      miscompares++;
    end
    run = 1'b0;
    go(8'h10, 1'b0);
    wait_done(60, at);
    vectors++;
    if (at !== 15 || starts.size() !== 2 || retired !== 16'd2) begin
      $display("FAIL held_run_restart: done=%0d pulses=%0d retired=%0d expected 15 2 2", at, starts.size(), retired);
      miscompares++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h00000013;
    mem[8'h00] = 32'h00000000;
    mem[8'h10] = 32'h00500093;
    mem[8'h11] = 32'h00300113;
    mem[8'h12] = 32'h00000000;
    mem[8'h20] = 32'h11111111;
    mem[8'h30] = 32'h0000000A;
    mem[8'h31] = 32'h0000000B;
    mem[8'h32] = 32'h0000000C;
    mem[8'h33] = 32'h00000000;
    mem[8'hFF] = 32'h00000013;
    test_reset;
    test_program;
    test_halt_first;
    test_timeout;
    test_wrap;
    test_reset_mid;
    test_run_held;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
